regbank_bist_ctrl: RTL
======================

// Module: regbank_bist_ctrl
// PURPOSE
//  Initiator side of the register32_bank port (we3/wa3/wd3/ra1/ra2 -> rd1/rd2): built-in self-test controller.
//  On start, writes a pattern into all registers, reads them back two per cycle, then repeats with the inverted pattern.
//  Reports pass/fail and the first mismatch. Sits between the host datapath and the bank; host has the port only while idle.
// PARAMETERS
//  NREGS     32          registers in bank; even, == 2**AW
//  AW        5           address width
//  DW        32          data width
//  STEP      32'h11      pattern increment: P(i) = i*STEP (truncated to DW)
//  ZERO_REG  1           1: reg 0 hardwired to 0, expected value for reg 0 is 0 in both passes
// PORTS
//  clk        in   1   clock, rising edge
//  rst        in   1   asynchronous, active-low reset
//  start      in   1   test request, sampled in IDLE only
//  busy       out  1   test in progress
//  done       out  1   one-cycle pulse at test end
//  pass       out  1   last test passed (held)
//  fail       out  1   last test failed (held)
//  fail_addr  out  AW  register of first mismatch
//  fail_exp   out  DW  expected value at first mismatch
//  fail_got   out  DW  value read at first mismatch
//  host_we3/host_wa3/host_wd3/host_ra1/host_ra2  in  1/AW/DW/AW/AW  host access to bank
//  host_rd1/host_rd2  out  DW  = rd1/rd2, always passed through
//  we3/wa3/wd3/ra1/ra2  out  1/AW/DW/AW/AW  bank port
//  rd1/rd2    in   DW  bank read data (combinational from ra1/ra2)
// BEHAVIOUR
//  - Reset (rst=0, async): state IDLE, counter 0; busy=done=pass=fail=0, fail_addr/exp/got=0.
//  - States: IDLE -> WR0 -> RD0 -> WR1 -> RD1 -> DONE -> IDLE.
//  - IDLE: bank port = host_* inputs. start=1 at an edge -> WR0, clears pass/fail/fail_* regs.
//  - WRx: NREGS cycles, cnt=0..NREGS-1: we3=1, wa3=cnt, wd3=P(cnt) (WR0) or ~P(cnt) (WR1).
//  - RDx: NREGS/2 cycles, k=0..NREGS/2-1: we3=0, ra1=2k, ra2=2k+1; compare rd1/rd2 same cycle vs expected.
//  - Expected E(i) = pass0: P(i), pass1: ~P(i); E(0)=0 when ZERO_REG=1.
//  - Mismatch in RDx: latch first one (ra1 takes priority over ra2) into fail_addr/exp/got; next state DONE, fail=1.
//  - End of RD1, no mismatch: DONE, pass=1. pass/fail are set on DONE entry and held until the next accepted start.
//  - DONE: done=1 for exactly one cycle, then IDLE.
//  - busy=1 in WR0/RD0/WR1/RD1 only. Full run: 2*(NREGS+NREGS/2) = 96 busy cycles, done on cycle 97 after start edge.
//  - start while not IDLE: ignored. host_we3 while busy: ignored (never reaches bank).
//  - Counter wraps to 0 on every state change; no overflow beyond NREGS-1.
//  - rst mid-run: immediate return to IDLE with reset outputs; bank contents undefined; host regains port.
//  - Bank-port outputs: combinational from state/counter (IDLE: from host_*); status outputs registered.
// STRUCTURE
//  - Package regbank_pkg: bist_state_t enum {IDLE,WR0,RD0,WR1,RD1,DONE}; function bist_pattern(i, pass, STEP, ZERO_REG).
//  - Single module, no sub-module: FSM + counter + status registers + host/BIST mux.
// TESTING (bench instantiates register32_bank, ZERO_REG=1)
//  1 rst, start pulse, good bank -> busy 96 cycles, done pulse once, pass=1, fail=0.
//  2 force bank reg 7 bit 3 stuck-at-0 -> RD0 passes (0x77); RD1 fails: fail_addr=7, exp=32'hFFFF_FF88, got=32'hFFFF_FF80, done early.
//  3 idle: host writes reg 5=32'hDEAD_BEEF, host_ra1=5 -> host_rd1=32'hDEAD_BEEF; host_we3=1 during busy -> no bank write.
//  4 second start pulse 20 cycles into run -> ignored; exactly one done, at cycle 97.
//  5 rst low at cycle 40 -> busy/done/pass/fail=0 immediately; restart -> pass=1.
//  6 ZERO_REG=0 with hardwired-r0 bank -> fail in RD1: fail_addr=0, exp=32'hFFFF_FFFF, got=0.

Source files
------------

// File: rtl/regbank_pkg.sv
// Shared types and the test-pattern generator for the register-bank self-test controller.
package regbank_pkg;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    WR0  = 3'd1,
    RD0  = 3'd2,
    WR1  = 3'd3,
    RD1  = 3'd4,
    DONE = 3'd5
  } bist_state_t;

  // Wide result so any data width up to 64 bits can truncate it with a size cast.
  function automatic logic [63:0] bist_pattern(input int unsigned i, input logic inv,
                                               input logic [63:0] step, input logic zero_reg);
    logic [63:0] p;
    p = 64'(i) * step;
    if (inv) p = ~p;
    if (zero_reg && i == 0) p = '0;
    return p;
  endfunction

endpackage

// File: rtl/regbank_bist_ctrl.sv
// Self-test controller for a 3-port register bank: writes a pattern to every register,
// reads it back two per cycle, repeats inverted, and reports pass/fail with the first mismatch.
import regbank_pkg::*;

module regbank_bist_ctrl #(
  parameter int          NREGS    = 32,
  parameter int          AW       = 5,
  parameter int          DW       = 32,
  parameter int unsigned STEP     = 32'h11,
  parameter bit          ZERO_REG = 1'b1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  output logic          busy,
  output logic          done,
  output logic          pass,
  output logic          fail,
  output logic [AW-1:0] fail_addr,
  output logic [DW-1:0] fail_exp,
  output logic [DW-1:0] fail_got,
  input  logic          host_we3,
  input  logic [AW-1:0] host_wa3,
  input  logic [DW-1:0] host_wd3,
  input  logic [AW-1:0] host_ra1,
  input  logic [AW-1:0] host_ra2,
  output logic [DW-1:0] host_rd1,
  output logic [DW-1:0] host_rd2,
  output logic          we3,
  output logic [AW-1:0] wa3,
  output logic [DW-1:0] wd3,
  output logic [AW-1:0] ra1,
  output logic [AW-1:0] ra2,
  input  logic [DW-1:0] rd1,
  input  logic [DW-1:0] rd2,
  output logic [2:0]    dbg_state
);

  bist_state_t   state;
  logic [AW-1:0] cnt;
  logic          last_wr, last_rd, inv;
  logic [AW-1:0] addr_even, addr_odd;
  logic [DW-1:0] exp_even, exp_odd, pat_wr;
  logic          mis_even, mis_odd;

  assign last_wr   = (cnt == AW'(NREGS - 1));
  assign last_rd   = (cnt == AW'(NREGS / 2 - 1));
  assign inv       = (state == WR1) || (state == RD1);
  assign addr_even = {cnt[AW-2:0], 1'b0};
  assign addr_odd  = {cnt[AW-2:0], 1'b1};
  assign dbg_state = state;
  assign host_rd1  = rd1;
  assign host_rd2  = rd2;

  // Writes always store the raw pattern; only the expectation knows about a hardwired reg 0.
  always_comb begin
    pat_wr   = DW'(bist_pattern(32'(cnt), inv, 64'(STEP), 1'b0));
    exp_even = DW'(bist_pattern(32'(addr_even), inv, 64'(STEP), ZERO_REG));
    exp_odd  = DW'(bist_pattern(32'(addr_odd), inv, 64'(STEP), ZERO_REG));
    mis_even = (rd1 != exp_even);
    mis_odd  = (rd2 != exp_odd);
  end

  // Bank port: host owns it only in IDLE (which includes reset).
  always_comb begin
    we3 = 1'b0;
    wa3 = '0;
    wd3 = '0;
    ra1 = '0;
    ra2 = '0;
    case (state)
      IDLE: begin
        we3 = host_we3;
        wa3 = host_wa3;
        wd3 = host_wd3;
        ra1 = host_ra1;
        ra2 = host_ra2;
      end
      WR0, WR1: begin
        we3 = 1'b1;
        wa3 = cnt;
        wd3 = pat_wr;
      end
      RD0, RD1: begin
        ra1 = addr_even;
        ra2 = addr_odd;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      cnt       <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      pass      <= 1'b0;
      fail      <= 1'b0;
      fail_addr <= '0;
      fail_exp  <= '0;
      fail_got  <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            state     <= WR0;
            cnt       <= '0;
            busy      <= 1'b1;
            pass      <= 1'b0;
            fail      <= 1'b0;
            fail_addr <= '0;
            fail_exp  <= '0;
            fail_got  <= '0;
          end
        end
        WR0, WR1: begin
          if (last_wr) begin
            state <= (state == WR0) ? RD0 : RD1;
            cnt   <= '0;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        RD0, RD1: begin
          // ra1 wins when both read ports disagree in the same cycle.
          if (mis_even || mis_odd) begin
            state     <= DONE;
            cnt       <= '0;
            busy      <= 1'b0;
            done      <= 1'b1;
            fail      <= 1'b1;
            fail_addr <= mis_even ? addr_even : addr_odd;
            fail_exp  <= mis_even ? exp_even : exp_odd;
            fail_got  <= mis_even ? rd1 : rd2;
          end else if (last_rd) begin
            cnt <= '0;
            if (state == RD0) begin
              state <= WR1;
            end else begin
              state <= DONE;
              busy  <= 1'b0;
              done  <= 1'b1;
              pass  <= 1'b1;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        DONE: begin
          state <= IDLE;
          cnt   <= '0;
        end
        default: begin
          state <= IDLE;
          cnt   <= '0;
        end
      endcase
    end
  end

endmodule
